// File: rtl/cac_array.sv
// -----------------------------------------------------------------------------
// cac_array - multi-entry pipelined column/address comparator for BIRA.
//
// Holds DEPTH spare-allocation entries (address + bank tag, bank 0 = empty).
// Each accepted query is compared against every entry in parallel. The match
// vector is registered in stage S1. Stage S2 registers the hit flag, the
// lowest matching index and the optional match count, and presents them on
// the result port.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. q_ready is combinational from pipeline state and r_ready only; it never
// looks at q_valid. The producer may change q_* freely while q_ready is low.
//
// Optional feature macro: CAC_MATCH_CNT_EN
//   defined   : r_cnt is the registered popcount of r_vec
//   undefined : popcount logic removed, r_cnt tied to 0
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   clr                   invalidate all entries (wins over wr_en)
//   wr_en/wr_idx/wr_addr/wr_bnk   entry write; wr_bnk = 0 frees the entry
//   q_valid/q_ready/q_addr/q_bnk  query port
//   r_valid/r_ready       result handshake
//   r_hit/r_vec/r_idx/r_cnt       result payload
//   vld_cnt, full         registered occupancy of the entry storage
// -----------------------------------------------------------------------------
module cac_array #(
    parameter int ADDR_W = 10,
    parameter int BANK_W = 2,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3   // must equal $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bnk,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [ADDR_W-1:0] q_addr,
    input  logic [BANK_W-1:0] q_bnk,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_hit,
    output logic [DEPTH-1:0]  r_vec,
    output logic [IDX_W-1:0]  r_idx,
    output logic [IDX_W:0]    r_cnt,
    output logic [IDX_W:0]    vld_cnt,
    output logic              full
);

    // Entry storage
    logic [ADDR_W-1:0] r_ent_addr [DEPTH];
    logic [BANK_W-1:0] r_ent_bnk  [DEPTH];
    logic [IDX_W:0]    r_vld_cnt;
    logic              r_full;

    // Pipeline stages
    logic              r_s1_valid;
    logic [DEPTH-1:0]  r_s1_vec;
    logic              r_s2_valid;
    logic [DEPTH-1:0]  r_s2_vec;
    logic              r_s2_hit;
    logic [IDX_W-1:0]  r_s2_idx;
    logic [IDX_W:0]    r_s2_cnt;

    // Combinational
    logic [DEPTH-1:0]  w_match;
    logic              w_q_fire;
    logic              w_adv;
    logic [BANK_W-1:0] w_nxt_bnk [DEPTH];
    logic [IDX_W:0]    w_nxt_cnt;
    logic              w_s1_hit;
    logic [IDX_W-1:0]  w_s1_idx;
    logic [IDX_W:0]    w_s1_cnt;

    // S2 may advance when it is empty or its result is being consumed.
    assign w_adv    = !r_s2_valid || r_ready;
    assign q_ready  = !r_s1_valid || w_adv;
    assign w_q_fire = q_valid && q_ready;

    // Parallel compare against the storage as it is before this edge's write,
    // so a same-cycle write to a matching entry is not seen by the query.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = (r_ent_bnk[i] != '0) && (q_bnk != '0) &&
                         (r_ent_addr[i] == q_addr) && (r_ent_bnk[i] == q_bnk);
        end
    end

    // Next bank tags after clr/write; vld_cnt/full are counted from this so
    // they reflect storage immediately after the update edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt_bnk[i] = r_ent_bnk[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_nxt_bnk[i] = '0;
            end
        end else if (wr_en) begin
            w_nxt_bnk[wr_idx] = wr_bnk;
        end
        w_nxt_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_nxt_bnk[i] != '0) begin
                w_nxt_cnt = w_nxt_cnt + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_addr[i] <= '0;
                r_ent_bnk[i]  <= '0;
            end
            r_vld_cnt <= '0;
            r_full    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_bnk[i] <= w_nxt_bnk[i];
            end
            // clr only invalidates; addresses are left in place.
            if (wr_en && !clr) begin
                r_ent_addr[wr_idx] <= wr_addr;
            end
            r_vld_cnt <= w_nxt_cnt;
            r_full    <= (w_nxt_cnt == (IDX_W+1)'(DEPTH));
        end
    end

    // S1: register the raw match vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_vec   <= '0;
        end else if (w_q_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_vec   <= w_match;
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Reduce the S1 vector: hit, lowest set index (0 when none), popcount.
    always_comb begin
        w_s1_hit = |r_s1_vec;
        w_s1_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_s1_vec[i]) begin
                w_s1_idx = IDX_W'(i);
            end
        end
    end

`ifdef CAC_MATCH_CNT_EN
    always_comb begin
        w_s1_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_s1_cnt = w_s1_cnt + {{IDX_W{1'b0}}, r_s1_vec[i]};
        end
    end
`else
    assign w_s1_cnt = '0;
`endif

    // S2: result register; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_vec   <= '0;
            r_s2_hit   <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_cnt   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_vec <= r_s1_vec;
                r_s2_hit <= w_s1_hit;
                r_s2_idx <= w_s1_idx;
                r_s2_cnt <= w_s1_cnt;
            end
        end
    end

    assign r_valid = r_s2_valid;
    assign r_hit   = r_s2_hit;
    assign r_vec   = r_s2_vec;
    assign r_idx   = r_s2_idx;
    assign r_cnt   = r_s2_cnt;
    assign vld_cnt = r_vld_cnt;
    assign full    = r_full;

endmodule
